biquad8_coeff_loader: RTL and testbench

// Single-clock WISHBONE initiator that sequences a full coefficient reload of one biquad8 filter

---
 rtl/biquad8_coeff_loader.sv | 186 ++++++++++++++++++
 tb/tb_biquad8_coeff_loader.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biquad8_coeff_loader.sv
// Coefficient reload sequencer for one biquad8 channel.
// A local table of {reg address, coefficient} entries is replayed as WISHBONE
// writes, optionally followed by a write of 1 to the update register at 0x00.
module biquad8_coeff_loader #(
    parameter int unsigned AW      = 5,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          tbl_wr_i,
    input  logic [AW-1:0] tbl_adr_i,
    input  logic [24:0]   tbl_dat_i,
    input  logic          start_i,
    input  logic [AW:0]   nent_i,
    input  logic          do_update_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic          m_wb_cyc_o,
    output logic          m_wb_stb_o,
    output logic          m_wb_we_o,
    output logic [6:0]    m_wb_adr_o,
    output logic [31:0]   m_wb_dat_o,
    output logic [3:0]    m_wb_sel_o,
    input  logic          m_wb_ack_i,
    input  logic          m_wb_err_i
);

    localparam int unsigned CW     = $clog2(TIMEOUT);
    localparam logic [AW:0] DepthW = {1'b1, {AW{1'b0}}};

    typedef enum logic [2:0] {StIdle, StFetch, StWrite, StUpd, StDone} state_e;

    state_e        state_q, state_d;
    logic [AW:0]   idx_q, idx_d;
    logic [AW:0]   nent_q, nent_d;
    logic          upd_q, upd_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          bus_q, bus_d;
    logic [6:0]    adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [CW-1:0] tcnt_q, tcnt_d;

    // Register address lsbs are never used: targets are word addressed.
    logic [22:0]   mem [2**AW];
    logic [22:0]   rd_ent;
    logic [AW:0]   nent_clamp;
    logic          unused_adr_lsb;

    assign unused_adr_lsb = ^tbl_dat_i[19:18];
    assign rd_ent         = mem[idx_q[AW-1:0]];
    assign nent_clamp     = (nent_i > DepthW) ? DepthW : nent_i;

    // Table RAM write port; contents survive reset.
    always_ff @(posedge wb_clk_i) begin
        if (tbl_wr_i && !busy_q) begin
            mem[tbl_adr_i] <= {tbl_dat_i[24:20], tbl_dat_i[17:0]};
        end
    end

    // Sequencer next-state and registered bus outputs.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        nent_d  = nent_q;
        upd_d   = upd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        bus_d   = bus_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        tcnt_d  = tcnt_q;

        // busy stays up through the done pulse so a start there is ignored
        if (done_q) begin
            busy_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (start_i && !busy_q) begin
                    busy_d = 1'b1;
                    err_d  = 1'b0;
                    nent_d = nent_clamp;
                    upd_d  = do_update_i;
                    idx_d  = '0;
                    if (nent_clamp != '0) begin
                        state_d = StFetch;
                    end else if (do_update_i) begin
                        // No RAM read needed: issue the update write right away
                        state_d = StUpd;
                        bus_d   = 1'b1;
                        adr_d   = '0;
                        dat_d   = 32'h1;
                        tcnt_d  = '0;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StFetch: begin
                bus_d   = 1'b1;
                adr_d   = {rd_ent[22:18], 2'b00};
                dat_d   = {14'b0, rd_ent[17:0]};
                tcnt_d  = '0;
                state_d = StWrite;
            end
            StWrite, StUpd: begin
                if (!bus_q) begin
                    // Update after a data write: one idle bus cycle has passed
                    bus_d  = 1'b1;
                    adr_d  = '0;
                    dat_d  = 32'h1;
                    tcnt_d = '0;
                end else if (m_wb_err_i ||
                             (!m_wb_ack_i && tcnt_q == CW'(TIMEOUT - 1))) begin
                    bus_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else if (m_wb_ack_i) begin
                    bus_d = 1'b0;
                    if (state_q == StUpd) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (idx_d == nent_q) begin
                            state_d = upd_q ? StUpd : StDone;
                        end else begin
                            state_d = StFetch;
                        end
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            nent_q  <= '0;
            upd_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            bus_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            nent_q  <= nent_d;
            upd_q   <= upd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            bus_q   <= bus_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign m_wb_cyc_o = bus_q;
    assign m_wb_stb_o = bus_q;
    assign m_wb_we_o  = bus_q;
    assign m_wb_sel_o = {4{bus_q}};
    assign m_wb_adr_o = adr_q;
    assign m_wb_dat_o = dat_q;

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// Bench for biquad8_coeff_loader: transaction-level expectation queue built from a
// table model, a scripted WISHBONE responder, and a negedge compare process.
module tb_biquad8_coeff_loader;

    localparam int unsigned AW    = 5;
    localparam int unsigned TO    = 16;
    localparam int          DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tbl_wr = 1'b0;
    logic [AW-1:0] tbl_adr = '0;
    logic [24:0]   tbl_dat = '0;
    logic          start = 1'b0;
    logic [AW:0]   nent = '0;
    logic          do_upd = 1'b0;
    logic          busy, done, err, cyc, stb, we;
    logic [6:0]    adr;
    logic [31:0]   dat;
    logic [3:0]    sel;
    logic          ack = 1'b0;
    logic          werr = 1'b0;

    always #5 clk = ~clk;

    biquad8_coeff_loader #(.AW(AW), .TIMEOUT(TO)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .tbl_wr_i    (tbl_wr),
        .tbl_adr_i   (tbl_adr),
        .tbl_dat_i   (tbl_dat),
        .start_i     (start),
        .nent_i      (nent),
        .do_update_i (do_upd),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .m_wb_cyc_o  (cyc),
        .m_wb_stb_o  (stb),
        .m_wb_we_o   (we),
        .m_wb_adr_o  (adr),
        .m_wb_dat_o  (dat),
        .m_wb_sel_o  (sel),
        .m_wb_ack_i  (ack),
        .m_wb_err_i  (werr)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    typedef struct packed {
        logic [6:0]  adr;
        logic [31:0] dat;
        logic [15:0] len;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         cur;
    bit          cur_valid = 0;
    logic [24:0] tbl_m [DEPTH];
    int          plan_kind [64];   // 0 ack, 1 err, 2 never answer
    int          plan_dly [64];
    int          wr_n = 0;
    bit          exp_err = 0;
    bit          done_pending = 0;
    bit          mon_en = 0;
    logic [6:0]  obs_adr [64];
    logic [31:0] obs_dat [64];
    int          obs_n = 0;

    // Responder: answers write number wr_n after plan_dly cycles of stb.
    int r_cnt = 0;
    bit r_prev = 0;
    always @(posedge clk) begin
        #1;
        if (stb) begin
            if (!r_prev) r_cnt = 0;
            else r_cnt++;
            ack  = (plan_kind[wr_n] == 0) && (r_cnt == plan_dly[wr_n]);
            werr = (plan_kind[wr_n] == 1) && (r_cnt == plan_dly[wr_n]);
        end else begin
            ack  = 1'b0;
            werr = 1'b0;
            if (r_prev && wr_n < 63) wr_n++;
        end
        r_prev = stb;
    end

    // Compare process: every bus write and done pulse against the expectation.
    bit prev_stb = 0;
    bit prev_done = 0;
    int len = 0;
    always @(negedge clk) begin
        if (!mon_en) begin
            prev_stb  = 0;
            prev_done = 0;
        end else begin
            if (stb && !prev_stb) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    cur_valid = 0;
                    $display("FAIL unexpected_write actual adr=%0h dat=%0h required none", adr, dat);
                end else begin
                    cur = exp_q.pop_front();
                    cur_valid = 1;
                    chk("wr_adr", adr, cur.adr);
                    chk("wr_dat", dat, cur.dat);
                    chk("wr_sel", sel, 4'hF);
                    chk("wr_we", we, 1'b1);
                    chk("wr_cyc", cyc, 1'b1);
                end
                if (obs_n < 64) begin
                    obs_adr[obs_n] = adr;
                    obs_dat[obs_n] = dat;
                    obs_n++;
                end
                len = 1;
            end else if (stb && prev_stb) begin
                len++;
                if (cur_valid) begin
                    chk("hold_adr", adr, cur.adr);
                    chk("hold_dat", dat, cur.dat);
                    chk("hold_sel", sel, 4'hF);
                    chk("hold_cyc", cyc, 1'b1);
                end
            end else if (!stb && prev_stb) begin
                if (cur_valid) chk("stb_len", len, cur.len);
                chk("cyc_drop", cyc, 1'b0);
            end
            if (done) begin
                if (!done_pending) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_done actual=1 required=0");
                end else begin
                    chk("done_err", err, exp_err);
                    chk("done_left", exp_q.size(), 0);
                    chk("done_busy", busy, 1'b1);
                    done_pending = 0;
                end
            end
            if (prev_done) chk("busy_after_done", busy, 1'b0);
            prev_stb  = stb;
            prev_done = done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int i, input logic [6:0] a, input logic [17:0] c);
        tbl_wr  = 1'b1;
        tbl_adr = AW'(i);
        tbl_dat = {a, c};
        tbl_m[i] = {a, c};
        tick();
        tbl_wr = 1'b0;
    endtask

    task automatic set_plan(input int kind, input bit rnd, input int dly);
        for (int i = 0; i < 64; i++) begin
            plan_kind[i] = kind;
            plan_dly[i]  = rnd ? int'($urandom_range(5, 0)) : dly;
        end
    endtask

    function automatic logic [15:0] plan_len(input int n);
        return (plan_kind[n] == 2) ? 16'(TO) : 16'(plan_dly[n] + 1);
    endfunction

    // Builds the expected write list, starts the sequence and waits for done.
    task automatic run_seq(input int n_in, input bit upd, input bit poke,
                           output int t_stb, output int t_done);
        int  n;
        int  wi;
        bit  aborted;
        wr_t w;
        n = (n_in > DEPTH) ? DEPTH : n_in;
        wi = 0;
        aborted = 0;
        for (int i = 0; i < n; i++) begin
            w.adr = {tbl_m[i][24:20], 2'b00};
            w.dat = {14'b0, tbl_m[i][17:0]};
            w.len = plan_len(wi);
            exp_q.push_back(w);
            wi++;
            if (plan_kind[wi-1] != 0) begin
                aborted = 1;
                break;
            end
        end
        if (upd && !aborted) begin
            w.adr = 7'h00;
            w.dat = 32'h1;
            w.len = plan_len(wi);
            exp_q.push_back(w);
        end
        exp_err = aborted;
        done_pending = 1;
        wr_n = 0;
        start  = 1'b1;
        nent   = (AW+1)'(n_in);
        do_upd = upd;
        tick();
        start  = 1'b0;
        t_stb  = -1;
        t_done = -1;
        for (int c = 1; c < 3000; c++) begin
            if (c == 1) begin
                chk("busy_c1", busy, 1'b1);
                chk("err_clr", err, 1'b0);
            end
            if (t_stb < 0 && stb) t_stb = c;
            if (done) begin
                t_done = c;
                if (poke) start = 1'b1;
                break;
            end
            if (poke && c == 3) begin
                start   = 1'b1;
                nent    = 6'd1;
                do_upd  = 1'b0;
                tbl_wr  = 1'b1;
                tbl_adr = 5'd1;
                tbl_dat = 25'h1ABCDEF;
            end
            if (poke && c == 4) begin
                start  = 1'b0;
                tbl_wr = 1'b0;
            end
            tick();
        end
        chk("done_seen", t_done >= 0, 1'b1);
        tick();
        start  = 1'b0;
        tbl_wr = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ts;
        int          td;
        logic [6:0]  la [4];
        logic [31:0] ld [4];
        la = '{7'h04, 7'h08, 7'h10, 7'h00};
        ld = '{32'h1234, 32'h3FFFF, 32'h1, 32'h1};
        set_plan(0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_cyc", cyc, 1'b0);
        chk("rst_stb", stb, 1'b0);
        chk("rst_we", we, 1'b0);
        chk("rst_sel", sel, 4'h0);
        chk("rst_adr", adr, 7'h0);
        chk("rst_dat", dat, 32'h0);
        mon_en = 1;

        for (int i = 0; i < DEPTH; i++) load(i, 7'(i * 4 + 3), 18'(i * 7919 + 5));
        load(0, 7'h04, 18'h01234);
        load(1, 7'h08, 18'h3FFFF);
        load(2, 7'h10, 18'h00001);

        // 1: three entries plus update, ack one cycle late
        set_plan(0, 0, 1);
        obs_n = 0;
        run_seq(3, 1, 0, ts, td);
        chk("t1_stb_lat", ts, 2);
        chk("t1_nwr", obs_n, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_lit_adr", obs_adr[i], la[i]);
            chk("t1_lit_dat", obs_dat[i], ld[i]);
        end
        chk("t1_err", err, 1'b0);

        // 2: update only
        obs_n = 0;
        run_seq(0, 1, 0, ts, td);
        chk("t2_stb_lat", ts, 1);
        chk("t2_nwr", obs_n, 1);
        chk("t2_adr", obs_adr[0], 7'h00);
        chk("t2_dat", obs_dat[0], 32'h1);

        // 3: nothing to do
        obs_n = 0;
        run_seq(0, 0, 0, ts, td);
        chk("t3_no_stb", ts, -1);
        chk("t3_done_lat", td, 2);
        chk("t3_nwr", obs_n, 0);
        chk("t3_busy", busy, 1'b0);

        // 4: second write never acked
        set_plan(0, 0, 1);
        plan_kind[1] = 2;
        obs_n = 0;
        run_seq(3, 1, 0, ts, td);
        chk("t4_err", err, 1'b1);
        chk("t4_nwr", obs_n, 2);

        // 5: error on first write, then full clamped reload with random delays
        set_plan(0, 1, 0);
        plan_kind[0] = 1;
        obs_n = 0;
        run_seq(3, 1, 0, ts, td);
        chk("t5_err", err, 1'b1);
        chk("t5_nwr", obs_n, 1);
        set_plan(0, 1, 0);
        obs_n = 0;
        run_seq(40, 1, 0, ts, td);
        chk("t5_clamp_nwr", obs_n, 33);
        chk("t5_ok", err, 1'b0);

        // 6: start/table writes while busy are dropped
        set_plan(0, 0, 0);
        run_seq(3, 1, 1, ts, td);
        chk("t6_idle", busy, 1'b0);
        set_plan(0, 1, 0);
        obs_n = 0;
        run_seq(3, 0, 0, ts, td);
        chk("t6_tbl_kept", obs_dat[1], 32'h3FFFF);

        // 6: async reset in the middle of a write
        set_plan(2, 0, 0);
        mon_en = 0;
        start  = 1'b1;
        nent   = 6'd1;
        do_upd = 1'b0;
        tick();
        start = 1'b0;
        for (int c = 0; c < 10 && !stb; c++) tick();
        chk("t6_stb_pre", stb, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_cyc", cyc, 1'b0);
        chk("t6_rst_stb", stb, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t6_no_done", done, 1'b0);
        end
        exp_q.delete();
        done_pending = 0;
        mon_en = 1;

        set_plan(0, 0, 2);
        obs_n = 0;
        run_seq(3, 1, 0, ts, td);
        chk("t7_nwr", obs_n, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
